alert_responder: RTL and testbench

- Consumer end of the driver-monitor alert path. Takes the warning/emergency levels produced by the safety state machine and drives the driver-facing and vehicle-facing actuators: buzzer pattern, amber/red indicators, hazard lights and a brake request.
- Handles driver acknowledge, snooze, timed escalation from warning to alarm, and delayed brake request in alarm.

---
 rtl/alert_responder.sv | 160 ++++++++++++++++
 tb/tb_alert_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alert_responder.sv
// Alert responder: turns warning/emergency levels into buzzer, indicator, hazard and brake requests.
// Optional event logging (warn_events/alarm_events) is enabled by defining ALERT_LOG_EN.
module alert_responder #(
  parameter int BEEP_HALF  = 4,
  parameter int ESC_CYC    = 32,
  parameter int SNOOZE_CYC = 64,
  parameter int BRAKE_DLY  = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       warning,
  input  logic       emergency,
  input  logic       driver_ack,
  output logic       buzzer,
  output logic       led_amber,
  output logic       led_red,
  output logic       hazard,
  output logic       brake_req,
  output logic [2:0] state_o
`ifdef ALERT_LOG_EN
  ,
  output logic [7:0] warn_events,
  output logic [7:0] alarm_events
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARN   = 3'd1,
    SNOOZE = 3'd2,
    ALARM  = 3'd3,
    BRAKE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] BEEP_TC = CNT_W'(BEEP_HALF - 1);
  localparam logic [CNT_W-1:0] ESC_TC  = CNT_W'(ESC_CYC - 1);
  localparam logic [CNT_W-1:0] SNZ_TC  = CNT_W'(SNOOZE_CYC - 1);
  localparam logic [CNT_W-1:0] BRK_TC  = CNT_W'(BRAKE_DLY - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] beep_cnt, esc_cnt, snz_cnt, brk_cnt;
  logic             beep_phase;
  logic             ack_prev, ack_pulse;
  logic             stay_warn, stay_snz, stay_alarm;

  assign ack_pulse  = driver_ack & ~ack_prev;
  assign stay_warn  = (state == WARN)   && (state_n == WARN);
  assign stay_snz   = (state == SNOOZE) && (state_n == SNOOZE);
  assign stay_alarm = (state == ALARM)  && (state_n == ALARM);

  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE: begin
        if (emergency)    state_n = ALARM;
        else if (warning) state_n = WARN;
        else              state_n = IDLE;
      end
      WARN: begin
        if (emergency)              state_n = ALARM;
        else if (!warning)          state_n = IDLE;
        else if (ack_pulse)         state_n = SNOOZE;
        else if (esc_cnt == ESC_TC) state_n = ALARM;
        else                        state_n = WARN;
      end
      SNOOZE: begin
        if (emergency)              state_n = ALARM;
        else if (!warning)          state_n = IDLE;
        else if (snz_cnt == SNZ_TC) state_n = WARN;
        else                        state_n = SNOOZE;
      end
      ALARM: begin
        if (ack_pulse && !emergency) state_n = IDLE;
        else if (brk_cnt == BRK_TC)  state_n = BRAKE;
        else                         state_n = ALARM;
      end
      BRAKE: begin
        if (ack_pulse && !emergency) state_n = IDLE;
        else                         state_n = BRAKE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Every timer clears whenever its state is entered or left, so idle timers sit at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack_prev   <= 1'b0;
      beep_cnt   <= '0;
      beep_phase <= 1'b0;
      esc_cnt    <= '0;
      snz_cnt    <= '0;
      brk_cnt    <= '0;
    end else begin
      state    <= state_n;
      ack_prev <= driver_ack;
      if (stay_warn) begin
        esc_cnt <= (esc_cnt == ESC_TC) ? esc_cnt : esc_cnt + 1'b1;
        if (beep_cnt == BEEP_TC) begin
          beep_cnt   <= '0;
          beep_phase <= ~beep_phase;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
        end
      end else begin
        esc_cnt    <= '0;
        beep_cnt   <= '0;
        beep_phase <= (state_n == WARN);
      end
      snz_cnt <= stay_snz ? ((snz_cnt == SNZ_TC) ? snz_cnt : snz_cnt + 1'b1) : '0;
      brk_cnt <= stay_alarm ? ((brk_cnt == BRK_TC) ? brk_cnt : brk_cnt + 1'b1) : '0;
    end
  end

  always_comb begin
    buzzer    = 1'b0;
    led_amber = 1'b0;
    led_red   = 1'b0;
    hazard    = 1'b0;
    brake_req = 1'b0;
    case (state)
      WARN: begin
        led_amber = 1'b1;
        buzzer    = beep_phase;
      end
      SNOOZE: led_amber = 1'b1;
      ALARM: begin
        buzzer  = 1'b1;
        led_red = 1'b1;
        hazard  = 1'b1;
      end
      BRAKE: begin
        buzzer    = 1'b1;
        led_red   = 1'b1;
        hazard    = 1'b1;
        brake_req = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef ALERT_LOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      warn_events  <= 8'd0;
      alarm_events <= 8'd0;
    end else begin
      if (state == IDLE && state_n == WARN && warn_events != 8'hFF)
        warn_events <= warn_events + 8'd1;
      if (state != ALARM && state_n == ALARM && alarm_events != 8'hFF)
        alarm_events <= alarm_events + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alert_responder.sv
// Self-checking bench for alert_responder: directed test-plan steps followed by randomized
// stimulus, all compared against a dwell-time reference model of the alert rules.
module tb_alert_responder;

  localparam int BEEP_HALF  = 4;
  localparam int ESC_CYC    = 32;
  localparam int SNOOZE_CYC = 64;
  localparam int BRAKE_DLY  = 16;

  logic       clk = 1'b0;
  logic       rst, warning, emergency, driver_ack;
  logic       buzzer, led_amber, led_red, hazard, brake_req;
  logic [2:0] state_o;
`ifdef ALERT_LOG_EN
  logic [7:0] warn_events, alarm_events;
`endif

  int checks = 0;
  int passes = 0;

  // Reference model: current state number, cycles spent in it, previous ack level
  int m_state = 0;
  int m_dwell = 0;
  bit m_ackp  = 1'b0;
  int m_warn_ev  = 0;
  int m_alarm_ev = 0;

  alert_responder #(
    .BEEP_HALF(BEEP_HALF), .ESC_CYC(ESC_CYC), .SNOOZE_CYC(SNOOZE_CYC),
    .BRAKE_DLY(BRAKE_DLY), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .warning(warning), .emergency(emergency),
    .driver_ack(driver_ack), .buzzer(buzzer), .led_amber(led_amber),
    .led_red(led_red), .hazard(hazard), .brake_req(brake_req), .state_o(state_o)
`ifdef ALERT_LOG_EN
    , .warn_events(warn_events), .alarm_events(alarm_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic modelStep(input bit r, input bit w, input bit e, input bit a);
    int nxt;
    bit p;
    if (r) begin
      m_state = 0; m_dwell = 0; m_ackp = 1'b0;
      m_warn_ev = 0; m_alarm_ev = 0;
      return;
    end
    p = a && !m_ackp;
    m_ackp = a;
    case (m_state)
      0: nxt = e ? 3 : (w ? 1 : 0);
      1: nxt = e ? 3 : (!w ? 0 : (p ? 2 : ((m_dwell >= ESC_CYC - 1) ? 3 : 1)));
      2: nxt = e ? 3 : (!w ? 0 : ((m_dwell >= SNOOZE_CYC - 1) ? 1 : 2));
      3: nxt = (p && !e) ? 0 : ((m_dwell >= BRAKE_DLY - 1) ? 4 : 3);
      default: nxt = (p && !e) ? 0 : 4;
    endcase
    if (m_state == 0 && nxt == 1 && m_warn_ev < 255) m_warn_ev++;
    if (m_state != 3 && nxt == 3 && m_alarm_ev < 255) m_alarm_ev++;
    m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
    m_state = nxt;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] obs, exp;
    bit ebuz;
    ebuz = (m_state == 1) ? (((m_dwell / BEEP_HALF) % 2) == 0) : (m_state >= 3);
    exp = {m_state[2:0], ebuz, (m_state == 1 || m_state == 2), (m_state >= 3),
           (m_state >= 3), (m_state == 4)};
    obs = {state_o, buzzer, led_amber, led_red, hazard, brake_req};
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: {state,buz,amb,red,haz,brk} observed=%b expected=%b", tag, obs, exp);
`ifdef ALERT_LOG_EN
    checks++;
    assert ({warn_events, alarm_events} === {m_warn_ev[7:0], m_alarm_ev[7:0]}) passes++;
    else $error("[TB] FAIL %s_log: observed=%0d/%0d expected=%0d/%0d", tag,
                warn_events, alarm_events, m_warn_ev, m_alarm_ev);
`endif
  endtask

  task automatic checkConst(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit r, input bit w, input bit e, input bit a, input string tag);
    rst = r; warning = w; emergency = e; driver_ack = a;
    @(posedge clk);
    modelStep(r, w, e, a);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit rw, re, ra, rr;
    rst = 1'b1; warning = 1'b0; emergency = 1'b0; driver_ack = 1'b0;

    // Reset
    applyStimulus(1, 0, 0, 0, "reset");
    applyStimulus(1, 0, 0, 0, "reset");
    checkConst("reset_state", {5'd0, state_o}, 8'd0);
    checkConst("reset_outs", {3'd0, buzzer, led_amber, led_red, hazard, brake_req}, 8'd0);
    applyStimulus(0, 0, 0, 0, "idle");

    // Warning held, no ack: beep pattern, escalation, brake
    for (int c = 1; c <= 60; c++) begin
      applyStimulus(0, 1, 0, 0, "warn_hold");
      if (c == 1)  checkConst("warn_c1", {6'd0, buzzer, led_amber}, 8'd3);
      if (c == 5)  checkConst("warn_c5_buz", {7'd0, buzzer}, 8'd0);
      if (c == 9)  checkConst("warn_c9_buz", {7'd0, buzzer}, 8'd1);
      if (c == 32) checkConst("warn_c32_state", {5'd0, state_o}, 8'd1);
      if (c == 33) checkConst("alarm_c33", {5'd0, led_red, hazard, led_amber}, 8'd6);
      if (c == 48) checkConst("brake_c48", {7'd0, brake_req}, 8'd0);
      if (c == 49) checkConst("brake_c49", {7'd0, brake_req}, 8'd1);
    end

    // Reset while in BRAKE, warning still high
    applyStimulus(1, 1, 0, 0, "rst_brake");
    checkConst("rst_brake_state", {5'd0, state_o}, 8'd0);
    checkConst("rst_brake_outs", {3'd0, buzzer, led_amber, led_red, hazard, brake_req}, 8'd0);
    applyStimulus(0, 1, 0, 0, "rewarn");
    checkConst("rewarn_state", {5'd0, state_o}, 8'd1);

    // Ack after some WARN cycles, held for 20 cycles: one snooze only
    for (int c = 2; c <= 10; c++) applyStimulus(0, 1, 0, 0, "warn_pre_ack");
    for (int k = 0; k <= 70; k++) begin
      applyStimulus(0, 1, 0, (k < 20), "snooze");
      if (k == 0)  checkConst("snooze_enter", {5'd0, state_o}, 8'd2);
      if (k == 63) checkConst("snooze_end", {5'd0, state_o, buzzer}, 8'd4);
      if (k == 64) checkConst("snooze_rewarn", {4'd0, state_o, buzzer}, 8'd3);
    end
    applyStimulus(0, 0, 0, 0, "warn_drop");
    checkConst("warn_drop_state", {5'd0, state_o}, 8'd0);

    // Emergency held, acks ignored, brake after delay, then release
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(0, 0, 1, (c == 5 || c == 30), "emerg");
      if (c == 16) checkConst("emerg_c16", {5'd0, state_o}, 8'd3);
      if (c == 17) checkConst("emerg_c17", {5'd0, state_o}, 8'd4);
    end
    applyStimulus(0, 0, 0, 0, "emerg_drop");
    applyStimulus(0, 0, 0, 1, "emerg_ack");
    checkConst("emerg_ack_outs", {state_o, buzzer, led_amber, led_red, hazard, brake_req}, 8'd0);
    applyStimulus(0, 0, 0, 0, "idle2");

    // Warning and emergency together; ack coincident with brake terminal count
    applyStimulus(0, 1, 1, 0, "both");
    checkConst("both_state", {5'd0, state_o}, 8'd3);
    checkConst("both_amber", {7'd0, led_amber}, 8'd0);
    for (int j = 1; j <= 15; j++) applyStimulus(0, 1, 0, 0, "alarm_wait");
    applyStimulus(0, 1, 0, 1, "ack_tc");
    checkConst("ack_tc_state", {5'd0, state_o, brake_req}, 8'd0);
    applyStimulus(0, 0, 0, 0, "idle3");

    // Randomized stimulus against the model
    rw = 0; re = 0; ra = 0; rr = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(19) == 0) rw = ~rw;
      if ($urandom_range(59) == 0) re = ~re;
      if ($urandom_range(5) == 0)  ra = ~ra;
      rr = ($urandom_range(299) == 0);
      applyStimulus(rr, rw, re, ra, "random");
    end

`ifdef ALERT_LOG_EN
    applyStimulus(1, 0, 0, 0, "log_reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, "log_warn");
      applyStimulus(0, 0, 0, 0, "log_idle");
    end
    applyStimulus(0, 0, 1, 0, "log_emerg");
    checkConst("log_counts_warn", warn_events, 8'd3);
    checkConst("log_counts_alarm", alarm_events, 8'd1);
    applyStimulus(0, 0, 0, 1, "log_ack");
    applyStimulus(0, 0, 0, 0, "log_rel");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(0, 0, 1, 0, "log_sat_e");
      applyStimulus(0, 0, 0, 1, "log_sat_a");
      applyStimulus(0, 0, 0, 0, "log_sat_r");
    end
    checkConst("log_sat_alarm", alarm_events, 8'd255);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
